// File: rtl/rv32_cpu_cp_mul_radix.sv
// Radix-2^BPC sequential multiplier for the RV32 M-extension (MUL, MULH, MULHSU, MULHU).
// Optional feature MUL_ZERO_BYPASS_EN: a zero operand completes one cycle after start with o_prod=0.
`timescale 1ns/1ps
module rv32_cpu_cp_mul_radix #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic            i_cpu_trap,
    input  logic [2:0]      i_mul_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_prod,
    output logic            o_valid,
    output logic            o_busy
);
    localparam int unsigned NCYC = XLEN / BPC;
    localparam int unsigned CW   = $clog2(NCYC + 1);
    localparam int unsigned AW   = XLEN + 1;
    localparam int unsigned SW   = XLEN + BPC + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [AW-1:0]   a_q;
    logic            b_top_q;
    logic [AW-1:0]   hi_q;
    // Unconsumed multiplier bits; finished product bits enter from the top.
    logic [XLEN-1:0] lo_q;

    logic                  a_sgn_c;
    logic                  b_sgn_c;
    logic                  last_c;
    logic [BPC:0]          chunk_c;
    logic signed [SW-1:0]  acc_c;
    logic signed [SW-1:0]  mcand_c;
    logic signed [SW-1:0]  mplr_c;
    logic signed [SW-1:0]  sum_c;
    logic [XLEN+BPC-1:0]   lo_cat_c;
    logic [AW-1:0]         hi_d;
    logic [XLEN-1:0]       lo_d;
    logic [XLEN-1:0]       res_d;
    logic                  unused_c;

    assign unused_c = i_mul_op[2];

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_c;
    assign zero_c = (i_rs1 == '0) || (i_rs2 == '0);
`endif

    // One radix step: the final chunk of a signed multiplier carries its top bit with negative weight.
    always_comb begin
        a_sgn_c  = (i_mul_op[1:0] == 2'b01) || (i_mul_op[1:0] == 2'b10);
        b_sgn_c  = (i_mul_op[1:0] == 2'b01);
        last_c   = (cnt_q == '0);
        chunk_c  = {last_c & b_top_q, lo_q[BPC-1:0]};
        acc_c    = {{BPC{hi_q[XLEN]}}, hi_q};
        mcand_c  = {{BPC{a_q[XLEN]}}, a_q};
        mplr_c   = {{XLEN{chunk_c[BPC]}}, chunk_c};
        sum_c    = acc_c + mcand_c * mplr_c;
        lo_cat_c = {sum_c[BPC-1:0], lo_q};
        hi_d     = sum_c[SW-1:BPC];
        lo_d     = XLEN'(lo_cat_c >> BPC);
        res_d    = (op_q == 2'b00) ? lo_d : hi_d[XLEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (state_q == S_IDLE && i_start) begin
            op_q    <= i_mul_op[1:0];
            a_q     <= {a_sgn_c & i_rs1[XLEN-1], i_rs1};
            b_top_q <= b_sgn_c & i_rs2[XLEN-1];
            hi_q    <= '0;
            lo_q    <= i_rs2;
        end else if (state_q == S_BUSY) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Control FSM; trap wins over completion in S_BUSY.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            o_prod  <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy  <= 1'b1;
                        cnt_q   <= CW'(NCYC - 1);
                        state_q <= S_BUSY;
`ifdef MUL_ZERO_BYPASS_EN
                        if (zero_c) begin
                            state_q <= S_DONE;
                            o_prod  <= '0;
                            o_valid <= 1'b1;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    if (i_cpu_trap) begin
                        state_q <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (last_c) begin
                        state_q <= S_DONE;
                        o_prod  <= res_d;
                        o_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
